// File: rtl/nios2_mult_arbiter.sv
// Two-port arbiter and sequencer in front of a shared 32x32 multiplier cell.
// Define MULT_ARB_HIGH_EN to add four-pass high-word (product[63:32]) sequencing.
module nios2_mult_arbiter #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req0_high,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic        req1_high,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [31:0] rsp_data,
    output logic [31:0] mul_src1,
    output logic [31:0] mul_src2,
    input  logic [31:0] mul_cell_result
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]  r_state;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic        r_id;
    logic        r_lastGrant;
    logic        w_idle;
    logic        w_grant1;
    logic        w_accept;
    logic        w_lastPass;
    logic [31:0] w_selA;
    logic [31:0] w_selB;
    logic [31:0] w_result;

    assign w_idle = (r_state == S_IDLE);

    // r_lastGrant=1 means port 1 went last, so a tie goes to port 0 after reset.
    assign w_grant1   = req1_valid & (~req0_valid | (~FIXED_PRIO & ~r_lastGrant));
    assign req0_ready = w_idle & req0_valid & ~w_grant1;
    assign req1_ready = w_idle & w_grant1;
    assign w_accept   = req0_ready | req1_ready;
    assign w_selA     = w_grant1 ? req1_a : req0_a;
    assign w_selB     = w_grant1 ? req1_b : req0_b;
    assign rsp_valid  = (r_state == S_RESP);

`ifdef MULT_ARB_HIGH_EN
    logic        r_high;
    logic [1:0]  r_pass;
    logic [1:0]  r_capPass;
    logic [63:0] r_acc;
    logic        w_selHigh;
    logic [63:0] w_pp;
    logic [63:0] w_accNext;

    assign w_selHigh  = w_grant1 ? req1_high : req0_high;
    assign w_lastPass = ~r_high | (r_pass == 2'd3);
    assign w_accNext  = r_acc + w_pp;
    assign w_result   = r_high ? w_accNext[63:32] : mul_cell_result;

    // Partial product of the pass issued last cycle, placed at its weight.
    always_comb begin
        w_pp = {32'h0, mul_cell_result};
        case (r_capPass)
            2'd1, 2'd2: w_pp = {16'h0, mul_cell_result, 16'h0};
            2'd3:       w_pp = {mul_cell_result, 32'h0};
            default:    w_pp = {32'h0, mul_cell_result};
        endcase
    end

    always_comb begin
        mul_src1 = '0;
        mul_src2 = '0;
        if (r_state == S_ISSUE) begin
            if (r_high) begin
                mul_src1 = {16'h0, r_pass[1] ? r_a[31:16] : r_a[15:0]};
                mul_src2 = {16'h0, r_pass[0] ? r_b[31:16] : r_b[15:0]};
            end else begin
                mul_src1 = r_a;
                mul_src2 = r_b;
            end
        end
    end

    // Pass 0's product first appears while pass 1 is being issued; the final
    // pass is folded in during DRAIN through w_accNext.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_high    <= 1'b0;
            r_pass    <= 2'd0;
            r_capPass <= 2'd0;
            r_acc     <= 64'h0;
        end else if (w_accept) begin
            r_high <= w_selHigh;
            r_pass <= 2'd0;
            r_acc  <= 64'h0;
        end else if (r_state == S_ISSUE) begin
            r_capPass <= r_pass;
            if (!w_lastPass) r_pass <= r_pass + 2'd1;
            if (r_pass != 2'd0) r_acc <= w_accNext;
        end
    end
`else
    logic w_unusedHigh;

    assign w_unusedHigh = req0_high ^ req1_high;
    assign w_lastPass   = 1'b1;
    assign w_result     = mul_cell_result;
    assign mul_src1     = (r_state == S_ISSUE) ? r_a : 32'h0;
    assign mul_src2     = (r_state == S_ISSUE) ? r_b : 32'h0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_a         <= 32'h0;
            r_b         <= 32'h0;
            r_id        <= 1'b0;
            r_lastGrant <= 1'b1;
            rsp_id      <= 1'b0;
            rsp_data    <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a         <= w_selA;
                        r_b         <= w_selB;
                        r_id        <= w_grant1;
                        r_lastGrant <= w_grant1;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (w_lastPass) r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    rsp_data <= w_result;
                    rsp_id   <= r_id;
                    r_state  <= S_RESP;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
